// File: rtl/tff_bank_sequencer.sv
// Sequences the toggle-enable vector of a T flip-flop bank to run
// load / count-up / count-down / invert commands over a valid/ready port.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_len, cmd_data : command handshake
//   stop        : synchronous abort while running
//   t_vec       : T-enable pattern applied at the next edge
//   q, qbar     : bank state and its complement
//   busy, done, wrap : status (done and wrap are one-cycle pulses)

module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= q ^ t;
  end

endmodule

module tff_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             stop,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] rem_q;
  logic             wrap_q;
  logic [WIDTH-1:0] run_t;
  logic             step;
  logic             accept;

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .reset (reset),
    .t     (t_vec),
    .q     (q)
  );

  assign qbar      = ~q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign wrap      = wrap_q;
  assign accept    = cmd_ready && cmd_valid;

  // a toggle step happens only in RUN with steps left and no abort
  assign step = (state_q == RUN) && !stop && (rem_q != '0);

  always_comb begin
    logic c;
    run_t = '1;
    c     = 1'b1;
    unique case (op_q)
      OP_LOAD: run_t = q ^ data_q;
      OP_UP: begin
        for (int i = 0; i < WIDTH; i++) begin
          run_t[i] = c;
          c        = c & q[i];
        end
      end
      OP_DOWN: begin
        for (int i = 0; i < WIDTH; i++) begin
          run_t[i] = c;
          c        = c & qbar[i];
        end
      end
      default: run_t = '1;
    endcase
  end

  assign t_vec = step ? run_t : '0;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (cmd_valid) state_d = RUN;
      state_q == RUN: begin
        if (stop || rem_q <= LEN_W'(1))
          state_d = DONE;
      end
      state_q == DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        rem_q  <= (cmd_op == OP_LOAD) ? LEN_W'(1) : cmd_len;
      end else if (step) begin
        rem_q <= rem_q - LEN_W'(1);
      end
      wrap_q <= step &&
                (((op_q == OP_UP) && (&q)) ||
                 ((op_q == OP_DOWN) && !(|q)));
    end
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: directed command table plus random
// commands checked cycle by cycle against an arithmetic model.

module tb_tff_bank_sequencer;

  localparam int W = 4;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         stop = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [L-1:0] cmd_len = '0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_ready, busy, done, wrap;
  logic [W-1:0] t_vec, q, qbar;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] mq = '0;

  typedef struct {
    logic [1:0]   op;
    int           len;
    logic [W-1:0] data;
    int           stop_at;
    logic [W-1:0] exp_q;
    int           exp_wraps;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  tff_bank_sequencer #(.WIDTH(W), .LEN_W(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .stop      (stop),
    .t_vec     (t_vec),
    .q         (q),
    .qbar      (qbar),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // next bank value for one step, from the arithmetic meaning of each op
  function automatic logic [W-1:0] nxt(input logic [1:0] op,
                                       input logic [W-1:0] cur,
                                       input logic [W-1:0] d);
    case (op)
      2'd0:    return d;
      2'd1:    return cur + 1'b1;
      2'd2:    return cur - 1'b1;
      default: return ~cur;
    endcase
  endfunction

  task automatic idle_chk(input string tag);
    logic [W-1:0] nb;
    nb = ~mq;
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tvec"}, t_vec, 0);
    chk({tag, "_q"}, q, mq);
    chk({tag, "_qbar"}, qbar, nb);
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len,
                         input logic [W-1:0] d, input int stop_at,
                         output int wraps);
    int n;
    logic [W-1:0] nq, nb;
    logic ew;
    wraps = 0;
    idle_chk("pre");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len[L-1:0];
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = (op == 2'd0) ? 1 : len;
    chk("ready_run", cmd_ready, 0);
    chk("busy_run", busy, 1);
    if (n == 0) begin
      chk("t_len0", t_vec, 0);
      @(posedge clk); #1;
      chk("q_len0", q, mq);
      chk("wrap_len0", wrap, 0);
    end
    for (int s = 0; s < n; s++) begin
      if (s == stop_at) begin
        stop = 1'b1;
        #1;
        chk("t_stop", t_vec, 0);
        @(posedge clk); #1;
        stop = 1'b0;
        chk("q_stop", q, mq);
        chk("wrap_stop", wrap, 0);
        break;
      end
      nq = nxt(op, mq, d);
      ew = (op == 2'd1 && mq == '1) || (op == 2'd2 && mq == '0);
      // junk commands while busy must be ignored
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_data  = W'($urandom);
      cmd_len   = L'($urandom);
      #1;
      chk("t_vec", t_vec, mq ^ nq);
      chk("done_run", done, 0);
      chk("busy_step", busy, 1);
      @(posedge clk); #1;
      nb = ~nq;
      chk("q_step", q, nq);
      chk("qbar_step", qbar, nb);
      chk("wrap_step", wrap, ew);
      mq = nq;
      if (ew) wraps++;
    end
    cmd_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("ready_done", cmd_ready, 0);
    chk("t_done", t_vec, 0);
    @(posedge clk); #1;
    chk("wrap_idle", wrap, 0);
    idle_chk("post");
  endtask

  initial begin
    int wr;
    int ln, sa;
    logic [1:0] op;

    tbl[0] = '{2'd0, 0,  4'b1010, -1, 4'b1010, 0};
    tbl[1] = '{2'd0, 0,  4'b1110, -1, 4'b1110, 0};
    tbl[2] = '{2'd1, 3,  4'b0000, -1, 4'b0001, 1};
    tbl[3] = '{2'd0, 0,  4'b0001, -1, 4'b0001, 0};
    tbl[4] = '{2'd2, 2,  4'b0000, -1, 4'b1111, 1};
    tbl[5] = '{2'd0, 0,  4'b0101, -1, 4'b0101, 0};
    tbl[6] = '{2'd3, 3,  4'b0000, -1, 4'b1010, 0};
    tbl[7] = '{2'd1, 0,  4'b0000, -1, 4'b1010, 0};
    tbl[8] = '{2'd0, 0,  4'b0000, -1, 4'b0000, 0};
    tbl[9] = '{2'd1, 10, 4'b0000, 3,  4'b0011, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 4'b0000);
    chk("rst_qbar", qbar, 4'b1111);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_tvec", t_vec, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].op, tbl[i].len, tbl[i].data, tbl[i].stop_at, wr);
      chk("tbl_q", q, tbl[i].exp_q);
      chk("tbl_wraps", wr, tbl[i].exp_wraps);
    end

    // reset in the middle of a long count
    run_cmd(2'd0, 0, 4'b0000, -1, wr);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_len   = 8'd200;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_q5", q, 4'd5);
    chk("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    mq = '0;
    idle_chk("arst");
    chk("arst_wrap", wrap, 0);
    @(posedge clk); #1;
    idle_chk("arst_hold");
    reset = 1'b1;
    @(posedge clk); #1;
    idle_chk("arst_rel");

    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      ln = $urandom_range(0, 20);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln) : -1;
      run_cmd(op, ln, W'($urandom), sa, wr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_bank_sequencer.md
# tff_bank_sequencer

- Controller that owns a WIDTH-bit bank of T flip-flops and sequences their toggle-enable (T) vector to run commands: load a value, count up, count down, or invert repeatedly for a programmed number of cycles.
- Commands arrive over a valid/ready handshake.
- The block reports completion, wrap-around and its live T pattern.
- Sits between a command source (CPU register or test sequencer) and the T-FF storage, which it instantiates internally.

## Interface
Parameters:
- WIDTH, 4, number of T flip-flops in the bank (≥2)
- LEN_W, 8, width of the step-count field

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset)
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 INVERT
- cmd_len  input  LEN_W  number of toggle steps (ignored for LOAD)
- cmd_data  input  WIDTH  target value for LOAD
- stop  input  1  synchronous abort of a running command
- t_vec  output  WIDTH  T-enable pattern applied at the next edge (0 outside RUN)
- q  output  WIDTH  bank state
- qbar  output  WIDTH  ~q, always
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- wrap  output  1  one-cycle pulse, the cycle after the bank wraps

## Operation
FSM states:
- IDLE
  - cmd_ready=1, t_vec=0.
  - On cmd_valid&cmd_ready: latch op, data.
  - rem <= (op==LOAD) ? 1 : cmd_len.
  - Go to RUN.
- RUN
  - t_vec is combinational from q and the latched op:
    - LOAD: t_vec = q ^ data.
    - UP: t[0]=1, t[i]=&q[i-1:0].
    - DOWN: t[0]=1, t[i]=&qbar[i-1:0].
    - INVERT: t_vec = all ones.
  - Each edge: q <= q ^ t_vec, rem <= rem-1.
  - Edge with rem==1: go to DONE.
  - rem==0 on entry (len=0): t_vec=0, no toggle, go to DONE.
  - stop=1 in RUN: t_vec forced 0, no toggle, go to DONE (stop beats the pending toggle).
- DONE
  - done=1, cmd_ready=0, t_vec=0.
  - Unconditionally go to IDLE.

Other rules:
- wrap is registered.
  - Set to 1 at an edge where UP moves q from all-ones to 0, or DOWN moves q from 0 to all-ones.
  - 0 at every other edge.
  - Never set by LOAD or INVERT.
- Arithmetic is modulo 2^WIDTH; rem is LEN_W bits and never underflows.
- cmd_valid outside IDLE is ignored and not queued.
- stop outside RUN is ignored.

## Timing
- Reset (async, reset=0):
  - q=0, qbar=all ones, state=IDLE.
  - rem=0, done=0, wrap=0, busy=0, t_vec=0, cmd_ready=1.
  - Asserting reset mid-command abandons it immediately: no done pulse.
- Command accepted at edge k with len=N≥1:
  - q updates at edges k+1..k+N.
  - done=1 and busy=1 during the cycle after edge k+N.
  - cmd_ready returns after edge k+N+1.
  - Earliest next accept is edge k+N+2.
- LOAD behaves as N=1: q equals cmd_data after edge k+1; done follows one cycle later.
- len=0: q unchanged; done during the cycle after edge k+1.
- stop sampled high at edge m in RUN: q holds its pre-m value; done during the cycle after m.
- wrap is high during the cycle following the wrapping edge; it may coincide with done.
- q/qbar change only at clock edges (or async reset); t_vec is valid combinationally throughout RUN.

## Test plan
- Reset then LOAD:
  - Stimulus: hold reset=0 for 2 cycles, release; LOAD data=4'b1010.
  - Response: during reset q=0000, qbar=1111, cmd_ready=1. First RUN cycle t_vec=1010; q=1010 after one edge; done pulse next cycle; wrap never set.
- UP count with wrap:
  - Stimulus: LOAD 4'b1110, then UP len=3.
  - Response: q sequence 1111, 0000, 0001. wrap high for exactly the cycle after the 1111→0000 edge. done after the third step.
- DOWN count with wrap:
  - Stimulus: LOAD 0001, then DOWN len=2.
  - Response: q 0000, 1111; wrap pulses once; t_vec on the 0000 step = 1111.
- INVERT and len=0:
  - Stimulus: LOAD 0101; INVERT len=3; then UP len=0.
  - Response: after INVERT q=1010. UP len=0 leaves q=1010 and still pulses done once.
- stop mid-run:
  - Stimulus: from q=0000, UP len=10; assert stop on the 4th RUN edge.
  - Response: q stops at 0011 (3 steps taken); done next cycle; cmd_valid during busy is ignored.
- Async reset mid-command:
  - Stimulus: UP len=200; pull reset low between edges after 5 steps.
  - Response: q=0000, busy=0, cmd_ready=1 immediately; no done pulse.
